// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state type and iteration-count helper for the iterative multiplier
package mul_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
   function automatic int mul_max_iters(input int width, input int digit);
      return width / digit;
   endfunction
endpackage

// File: rtl/mul_digit_step.sv
// mul_digit_step: adds one multiplier digit times the shifted multiplicand into the accumulator
module mul_digit_step #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [DIGIT-1:0]   digit,
   input  logic [2*WIDTH-1:0] mc,
   output logic [2*WIDTH-1:0] acc_nxt
);
   assign acc_nxt = acc + mc * {{(2*WIDTH-DIGIT){1'b0}}, digit};
endmodule

// File: rtl/multiplier_iterative_param.sv
// multiplier_iterative_param: handshaked digit-serial signed/unsigned multiplier with early exit
module multiplier_iterative_param
   import mul_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] r
);
   mul_state_t state, state_nxt;
   logic [WIDTH-1:0] mp, abs_a, abs_b;
   logic [2*WIDTH-1:0] acc, mc, acc_nxt;
   logic neg, accept;

   if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad_params
      $fatal(1, "multiplier_iterative_param: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
   assign abs_a = (in_signed && a[WIDTH-1]) ? -a : a;
   assign abs_b = (in_signed && b[WIDTH-1]) ? -b : b;

   mul_digit_step #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_step (
      .acc    (acc),
      .digit  (mp[DIGIT-1:0]),
      .mc     (mc),
      .acc_nxt(acc_nxt)
   );

   // handshake and next-state decode; a DONE-cycle accept skips the IDLE bubble
   always_comb begin
      in_ready  = (state == IDLE) || (state == DONE && out_ready);
      accept    = in_valid && in_ready;
      out_valid = (state == DONE);
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept ? BUSY : IDLE;
         BUSY:    state_nxt = (mp == '0) ? DONE : BUSY;
         DONE:    state_nxt = accept ? BUSY : (out_ready ? IDLE : DONE);
         default: state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // datapath: load magnitudes on accept, retire one digit per BUSY cycle, apply sign at the end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mp  <= '0;
         mc  <= '0;
         acc <= '0;
         neg <= 1'b0;
         r   <= '0;
      end else if (accept) begin
         mp  <= abs_a;
         mc  <= {{WIDTH{1'b0}}, abs_b};
         acc <= '0;
         neg <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (state == BUSY && mp != '0) begin
         acc <= acc_nxt;
         mp  <= mp >> DIGIT;
         mc  <= mc << DIGIT;
      end else if (state == BUSY) begin
         r <= neg ? -acc : acc;
      end
   end
endmodule

// File: tb/tb_multiplier_iterative_param.sv
// tb_multiplier_iterative_param: directed checks of three parameterisations of the iterative multiplier
module tb_multiplier_iterative_param;
   import mul_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] vld = '0;
   logic sgn = 1'b0;
   logic out_ready = 1'b0;
   logic [31:0] a_in = '0, b_in = '0;
   logic rdy0, rdy1, rdy2, ov0, ov1, ov2;
   logic [63:0] r0;
   logic [15:0] r1;
   logic [31:0] r2;
   int cur = 0;
   logic cur_rdy, cur_ov;
   logic [63:0] cur_r;
   int checks = 0;
   int failures = 0;
   int bound;

   always #5 clk = ~clk;

   multiplier_iterative_param #(.WIDTH(32), .DIGIT(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy0), .in_signed(sgn),
      .a(a_in), .b(b_in), .out_valid(ov0), .out_ready(out_ready), .r(r0));
   multiplier_iterative_param #(.WIDTH(8), .DIGIT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy1), .in_signed(sgn),
      .a(a_in[7:0]), .b(b_in[7:0]), .out_valid(ov1), .out_ready(out_ready), .r(r1));
   multiplier_iterative_param #(.WIDTH(16), .DIGIT(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy2), .in_signed(sgn),
      .a(a_in[15:0]), .b(b_in[15:0]), .out_valid(ov2), .out_ready(out_ready), .r(r2));

   always_comb begin
      cur_rdy = (cur == 1) ? rdy1 : (cur == 2) ? rdy2 : rdy0;
      cur_ov  = (cur == 1) ? ov1  : (cur == 2) ? ov2  : ov0;
      cur_r   = (cur == 1) ? {48'b0, r1} : (cur == 2) ? {32'b0, r2} : r0;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic wait_result(input string tag, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!cur_ov && n < bound);
      if (!cur_ov) chk({tag, "_timeout"}, 64'(cur_ov), 64'd1);
   endtask

   task automatic op(input int sel, input logic sg, input logic [31:0] av, input logic [31:0] bv,
                     input logic [63:0] er, input int el, input string tag);
      int n;
      cur = sel;
      @(negedge clk);
      a_in = av; b_in = bv; sgn = sg; vld[sel] = 1'b1;
      #1 chk({tag, "_in_ready_idle"}, 64'(cur_rdy), 64'd1);
      @(posedge clk); #1;
      vld = '0;
      chk({tag, "_in_ready_busy"}, 64'(cur_rdy), 64'd0);
      wait_result(tag, n);
      chk({tag, "_latency"}, 64'(n), 64'(el));
      chk({tag, "_r"}, cur_r, er);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_consumed"}, 64'(cur_ov), 64'd0);
   endtask

   initial begin
      int n;
      bound = mul_max_iters(8, 1) + 4;
      #2;
      chk("reset_in_ready", 64'(rdy0), 64'd1);
      chk("reset_out_valid", 64'(ov0), 64'd0);
      chk("reset_r", r0, 64'd0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;

      op(0, 0, 32'd7, 32'd6, 64'd42, 2, "w32_7x6");
      op(0, 0, 32'd0, 32'hFFFF_FFFF, 64'd0, 1, "w32_zero");
      op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 9, "w32_max");
      op(0, 1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 2, "w32_neg3x5");
      op(0, 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 9, "w32_minmin_s");
      op(0, 0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 9, "w32_minmin_u");

      op(1, 0, 32'd7, 32'd6, 64'd42, 4, "w8_7x6");
      op(1, 0, 32'd0, 32'hFF, 64'd0, 1, "w8_zero");
      op(1, 0, 32'hFF, 32'hFF, 64'hFE01, 9, "w8_max");
      op(1, 1, 32'hFD, 32'd5, 64'hFFF1, 3, "w8_neg3x5");
      op(1, 1, 32'h80, 32'h80, 64'h4000, 9, "w8_minmin_s");
      op(1, 0, 32'h80, 32'h80, 64'h4000, 9, "w8_minmin_u");

      op(2, 0, 32'd7, 32'd6, 64'd42, 2, "w16_7x6");
      op(2, 0, 32'd0, 32'hFFFF, 64'd0, 1, "w16_zero");
      op(2, 0, 32'hFFFF, 32'hFFFF, 64'hFFFE_0001, 3, "w16_max");
      op(2, 1, 32'hFFFD, 32'd5, 64'hFFFF_FFF1, 2, "w16_neg3x5");
      op(2, 1, 32'h8000, 32'h8000, 64'h4000_0000, 3, "w16_minmin_s");
      op(2, 0, 32'h8000, 32'h8000, 64'h4000_0000, 3, "w16_minmin_u");

      cur = 0;
      @(negedge clk);
      a_in = 32'd12; b_in = 32'd13; sgn = 1'b0; vld[0] = 1'b1;
      @(posedge clk); #1;
      vld = '0;
      wait_result("bp_first", n);
      chk("bp_first_r", r0, 64'd156);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a_in = 32'd5; b_in = 32'd5; vld[0] = 1'b1;
         @(posedge clk); #1;
         chk("bp_hold_valid", 64'(ov0), 64'd1);
         chk("bp_hold_r", r0, 64'd156);
         chk("bp_hold_in_ready", 64'(rdy0), 64'd0);
      end
      @(negedge clk);
      a_in = 32'd2; b_in = 32'd3; out_ready = 1'b1;
      #1 chk("bp_release_in_ready", 64'(rdy0), 64'd1);
      @(posedge clk); #1;
      vld = '0; out_ready = 1'b0;
      chk("bp_b2b_valid_drop", 64'(ov0), 64'd0);
      chk("bp_b2b_busy", 64'(rdy0), 64'd0);
      wait_result("bp_b2b", n);
      chk("bp_b2b_latency", 64'(n), 64'd2);
      chk("bp_b2b_r", r0, 64'd6);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      @(negedge clk);
      a_in = 32'h1234_5678; b_in = 32'd9; vld[0] = 1'b1;
      @(posedge clk); #1;
      vld = '0;
      @(posedge clk); @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", 64'(ov0), 64'd0);
      chk("rst_mid_r", r0, 64'd0);
      chk("rst_mid_in_ready", 64'(rdy0), 64'd1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_no_result", 64'(ov0), 64'd0);
      op(0, 0, 32'd10, 32'd10, 64'd100, 2, "after_rst_10x10");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
